// File: rtl/eeprom_arbiter_pkg.sv
// Shared types for the two-requester EEPROM arbiter: FSM encoding, field widths
// and the per-requester operation/write-beat bundles.
package eeprom_arbiter_pkg;

  localparam int unsigned N_REQ     = 2;
  localparam int unsigned EE_ADDR_W = 3;
  localparam int unsigned OP_ADDR_W = 16;
  localparam int unsigned OP_TYPE_W = 2;
  localparam int unsigned OP_LEN_W  = 8;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [EE_ADDR_W-1:0] eeprom_addr;
    logic [OP_ADDR_W-1:0] op_addr;
    logic [OP_TYPE_W-1:0] op_type;
    logic [OP_LEN_W-1:0]  op_len;
  } op_fields_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              valid;
  } wr_beat_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  function automatic logic is_wait(input arb_state_e st);
    return (st == ST_WAIT_BUSY) || (st == ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/eeprom_arbiter_rr_pick2.sv
// Two-way round-robin winner: on a tie the requester that did not win last time
// is chosen; a lone request always wins.
module rr_pick2
  import eeprom_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] valid_i,
  input  logic             last_grant_i,
  output logic             any_o,
  output logic             winner_o
);

  always_comb begin
    any_o    = |valid_i;
    winner_o = 1'b0;
    if (valid_i == 2'b11) begin
      winner_o = ~last_grant_i;
    end else if (valid_i[1]) begin
      winner_o = 1'b1;
    end
  end

endmodule

// File: rtl/eeprom_arbiter.sv
// Round-robin sharing of one eeprom_drive control port between two requesters,
// one grant per complete operation, with a watchdog that frees a hung grant.
module eeprom_arbiter
  import eeprom_arbiter_pkg::*;
#(
  parameter int unsigned P_TIMEOUT_CYC = 2_000_000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_REQ*EE_ADDR_W-1:0]   i_req_eeprom_addr,
  input  logic [N_REQ*OP_ADDR_W-1:0]   i_req_op_addr,
  input  logic [N_REQ*OP_TYPE_W-1:0]   i_req_op_type,
  input  logic [N_REQ*OP_LEN_W-1:0]    i_req_op_len,
  input  logic [N_REQ-1:0]             i_req_op_valid,
  output logic [N_REQ-1:0]             o_req_op_ready,
  input  logic [N_REQ*DATA_W-1:0]      i_req_wr_data,
  input  logic [N_REQ-1:0]             i_req_wr_sop,
  input  logic [N_REQ-1:0]             i_req_wr_eop,
  input  logic [N_REQ-1:0]             i_req_wr_valid,
  output logic [DATA_W-1:0]            o_req_rd_data,
  output logic [N_REQ-1:0]             o_req_rd_valid,
  output logic [EE_ADDR_W-1:0]         o_ctrl_eeprom_addr,
  output logic [OP_ADDR_W-1:0]         o_ctrl_op_addr,
  output logic [OP_TYPE_W-1:0]         o_ctrl_op_type,
  output logic [OP_LEN_W-1:0]          o_ctrl_op_len,
  output logic                         o_ctrl_op_valid,
  input  logic                         i_ctrl_op_ready,
  output logic [DATA_W-1:0]            o_ctrl_wr_data,
  output logic                         o_ctrl_wr_sop,
  output logic                         o_ctrl_wr_eop,
  output logic                         o_ctrl_wr_valid,
  input  logic [DATA_W-1:0]            i_ctrl_rd_data,
  input  logic                         i_ctrl_rd_valid,
  output logic [N_REQ-1:0]             o_grant,
  output logic                         o_timeout
);

  localparam int unsigned WDOG_W = (P_TIMEOUT_CYC > 1) ? $clog2(P_TIMEOUT_CYC) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(P_TIMEOUT_CYC - 1);

  arb_state_e        state_q;
  logic [N_REQ-1:0]  grant_q;
  logic              last_grant_q;
  logic [WDOG_W-1:0] wdog_q;
  logic [WDOG_W-1:0] wdog_d;
  logic              timeout_q;

  logic              gidx;
  logic              pick_any;
  logic              pick_idx;
  logic              in_wait;

  op_fields_t        req_op [N_REQ];
  wr_beat_t          req_wr [N_REQ];
  op_fields_t        sel_op;
  wr_beat_t          sel_wr;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_op[gi] = {i_req_eeprom_addr[gi*EE_ADDR_W +: EE_ADDR_W],
                           i_req_op_addr[gi*OP_ADDR_W +: OP_ADDR_W],
                           i_req_op_type[gi*OP_TYPE_W +: OP_TYPE_W],
                           i_req_op_len[gi*OP_LEN_W +: OP_LEN_W]};
      assign req_wr[gi] = {i_req_wr_data[gi*DATA_W +: DATA_W],
                           i_req_wr_sop[gi],
                           i_req_wr_eop[gi],
                           i_req_wr_valid[gi]};
    end
  endgenerate

  rr_pick2 u_rr_pick2 (
    .valid_i      (i_req_op_valid),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .winner_o     (pick_idx)
  );

  // grant_q is one-hot whenever not IDLE, so its upper bit is the owner index.
  assign gidx    = grant_q[1];
  assign in_wait = is_wait(state_q);
  assign wdog_d  = wdog_q + 1'b1;
  assign sel_op  = req_op[gidx];
  assign sel_wr  = req_wr[gidx];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          wdog_q <= '0;
          if (pick_any) begin
            grant_q <= idx_to_onehot(pick_idx);
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdog_q <= '0;
          if (!i_req_op_valid[gidx]) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end else if (i_ctrl_op_ready) begin
            last_grant_q <= gidx;
            state_q      <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          // A completion seen on the last watchdog cycle still counts as normal.
          if (state_q == ST_WAIT_DONE && i_ctrl_op_ready) begin
            grant_q <= '0;
            wdog_q  <= '0;
            state_q <= ST_IDLE;
          end else if (wdog_q == WDOG_LAST) begin
            grant_q   <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            wdog_q <= wdog_d;
            if (state_q == ST_WAIT_BUSY && !i_ctrl_op_ready) begin
              state_q <= ST_WAIT_DONE;
            end
          end
        end
        default: begin
          grant_q <= '0;
          wdog_q  <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_ctrl_eeprom_addr = '0;
    o_ctrl_op_addr     = '0;
    o_ctrl_op_type     = '0;
    o_ctrl_op_len      = '0;
    o_ctrl_op_valid    = 1'b0;
    o_req_op_ready     = '0;
    o_ctrl_wr_data     = '0;
    o_ctrl_wr_sop      = 1'b0;
    o_ctrl_wr_eop      = 1'b0;
    o_ctrl_wr_valid    = 1'b0;
    o_req_rd_valid     = '0;
    if (state_q != ST_IDLE) begin
      o_ctrl_eeprom_addr = sel_op.eeprom_addr;
      o_ctrl_op_addr     = sel_op.op_addr;
      o_ctrl_op_type     = sel_op.op_type;
      o_ctrl_op_len      = sel_op.op_len;
      o_ctrl_wr_data     = sel_wr.data;
      o_ctrl_wr_sop      = sel_wr.sop;
      o_ctrl_wr_eop      = sel_wr.eop;
      o_ctrl_wr_valid    = sel_wr.valid;
    end
    if (state_q == ST_ISSUE) begin
      o_ctrl_op_valid      = i_req_op_valid[gidx];
      o_req_op_ready[gidx] = i_ctrl_op_ready;
    end
    if (in_wait) begin
      o_req_rd_valid[gidx] = i_ctrl_rd_valid;
    end
  end

  assign o_req_rd_data = i_ctrl_rd_data;
  assign o_grant       = grant_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed bench for eeprom_arbiter with a small eeprom_drive responder
// (ready low 20 cycles after each accept, read bytes streamed while busy).
module tb_eeprom_arbiter;

  localparam int         P_TO  = 64;
  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [5:0]  req_eeprom_addr = '0;
  logic [31:0] req_op_addr = '0;
  logic [3:0]  req_op_type = '0;
  logic [15:0] req_op_len = '0;
  logic [1:0]  req_op_valid = '0;
  logic [1:0]  req_op_ready;
  logic [15:0] req_wr_data = '0;
  logic [1:0]  req_wr_sop = '0;
  logic [1:0]  req_wr_eop = '0;
  logic [1:0]  req_wr_valid = '0;
  logic [7:0]  req_rd_data;
  logic [1:0]  req_rd_valid;
  logic [2:0]  ctrl_eeprom_addr;
  logic [15:0] ctrl_op_addr;
  logic [1:0]  ctrl_op_type;
  logic [7:0]  ctrl_op_len;
  logic        ctrl_op_valid;
  logic        ctrl_ready = 1'b1;
  logic [7:0]  ctrl_wr_data;
  logic        ctrl_wr_sop, ctrl_wr_eop, ctrl_wr_valid;
  logic [7:0]  ctrl_rd_data = '0;
  logic        model_rd_valid = 1'b0;
  logic        force_rd = 1'b0;
  logic        ctrl_rd_valid;
  logic [1:0]  grant;
  logic        timeout;

  assign ctrl_rd_valid = model_rd_valid | force_rd;

  eeprom_arbiter #(.P_TIMEOUT_CYC(P_TO)) dut (
    .i_clk              (clk),
    .i_rst              (rst_n),
    .i_req_eeprom_addr  (req_eeprom_addr),
    .i_req_op_addr      (req_op_addr),
    .i_req_op_type      (req_op_type),
    .i_req_op_len       (req_op_len),
    .i_req_op_valid     (req_op_valid),
    .o_req_op_ready     (req_op_ready),
    .i_req_wr_data      (req_wr_data),
    .i_req_wr_sop       (req_wr_sop),
    .i_req_wr_eop       (req_wr_eop),
    .i_req_wr_valid     (req_wr_valid),
    .o_req_rd_data      (req_rd_data),
    .o_req_rd_valid     (req_rd_valid),
    .o_ctrl_eeprom_addr (ctrl_eeprom_addr),
    .o_ctrl_op_addr     (ctrl_op_addr),
    .o_ctrl_op_type     (ctrl_op_type),
    .o_ctrl_op_len      (ctrl_op_len),
    .o_ctrl_op_valid    (ctrl_op_valid),
    .i_ctrl_op_ready    (ctrl_ready),
    .o_ctrl_wr_data     (ctrl_wr_data),
    .o_ctrl_wr_sop      (ctrl_wr_sop),
    .o_ctrl_wr_eop      (ctrl_wr_eop),
    .o_ctrl_wr_valid    (ctrl_wr_valid),
    .i_ctrl_rd_data     (ctrl_rd_data),
    .i_ctrl_rd_valid    (ctrl_rd_valid),
    .o_grant            (grant),
    .o_timeout          (timeout)
  );

  always #5 clk = ~clk;

  // Drive responder: updates 1 time unit after each rising edge.
  int          busy = 0;
  int          rdcnt = 0;
  logic [7:0]  rd_idx = '0;
  logic        hang = 1'b0;
  logic        stall = 1'b0;
  logic        acc_seen = 1'b0;
  logic [1:0]  acc_type = '0;
  logic [7:0]  acc_len = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      ctrl_ready     = 1'b1;
      busy           = 0;
      rdcnt          = 0;
      model_rd_valid = 1'b0;
      ctrl_rd_data   = '0;
    end else begin
      model_rd_valid = 1'b0;
      ctrl_rd_data   = '0;
      if (acc_seen) begin
        busy       = 20;
        rdcnt      = (acc_type == OP_RD) ? int'(acc_len) : 0;
        rd_idx     = '0;
        ctrl_ready = 1'b0;
      end else begin
        if (rdcnt > 0) begin
          model_rd_valid = 1'b1;
          ctrl_rd_data   = 8'hA0 + rd_idx;
          rd_idx++;
          rdcnt--;
        end
        if (busy > 0) busy--;
        if (stall) ctrl_ready = 1'b0;
        else if (busy == 0 && !hang) ctrl_ready = 1'b1;
      end
    end
  end

  // Monitor on the falling edge, where every signal is settled.
  int          rdv0 = 0;
  int          rdv1 = 0;
  logic [7:0]  last_rd = '0;
  logic [9:0]  wr_log[$];
  int          order[$];

  always @(negedge clk) begin
    acc_seen = ctrl_op_valid && ctrl_ready;
    acc_type = ctrl_op_type;
    acc_len  = ctrl_op_len;
    if (req_rd_valid[0]) begin
      rdv0++;
      last_rd = req_rd_data;
    end
    if (req_rd_valid[1]) rdv1++;
    if (ctrl_wr_valid) wr_log.push_back({ctrl_wr_sop, ctrl_wr_eop, ctrl_wr_data});
    for (int i = 0; i < 2; i++) begin
      if (req_op_ready[i] && req_op_valid[i]) order.push_back(i);
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] ea, input logic [15:0] a,
                         input logic [1:0] t, input logic [7:0] l);
    req_eeprom_addr[i*3 +: 3] = ea;
    req_op_addr[i*16 +: 16]   = a;
    req_op_type[i*2 +: 2]     = t;
    req_op_len[i*8 +: 8]      = l;
  endtask

  // Wait for an accept, let it happen, then drop that requester's op_valid.
  task automatic serve_one(output int who);
    int k;
    k   = 0;
    who = -1;
    while (((req_op_ready & req_op_valid) == 2'b00) && k < 300) begin
      tick(1);
      k++;
    end
    chk("serve_bound", 32'(k < 300), 32'd1);
    if (k < 300) begin
      who = req_op_ready[1] ? 1 : 0;
      tick(1);
      req_op_valid[who] = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (grant != 2'b00 && k < 300) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(k < 300), 32'd1);
  endtask

  int who;
  int k;
  int n_order;
  logic [9:0] exp_beat [3];

  initial begin
    exp_beat = '{10'h211, 10'h022, 10'h133};

    // Reset state
    tick(2);
    chk("rst_grant", grant, 2'b00);
    chk("rst_op_valid", ctrl_op_valid, 1'b0);
    chk("rst_op_ready", req_op_ready, 2'b00);
    chk("rst_rd_valid", req_rd_valid, 2'b00);
    chk("rst_wr_valid", ctrl_wr_valid, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // T1: stray read data in IDLE dropped; lone req0 read of 4 bytes
    force_rd = 1'b1;
    tick(1);
    force_rd = 1'b0;
    chk("t1_idle_rd_drop", 32'(rdv0 + rdv1), 32'd0);
    set_req(0, 3'd5, 16'h0010, OP_RD, 8'd4);
    req_op_valid[0] = 1'b1;
    chk("t1_valid_cycle_n", ctrl_op_valid, 1'b0);
    tick(1);
    chk("t1_valid_cycle_n1", ctrl_op_valid, 1'b1);
    chk("t1_grant", grant, 2'b01);
    chk("t1_op_addr", ctrl_op_addr, 16'h0010);
    chk("t1_op_len", ctrl_op_len, 8'd4);
    chk("t1_eeprom_addr", ctrl_eeprom_addr, 3'd5);
    chk("t1_op_ready", req_op_ready, 2'b01);
    serve_one(who);
    chk("t1_who", who, 0);
    chk("t1_grant_wait", grant, 2'b01);
    wait_idle("t1_idle_bound");
    chk("t1_rd0_pulses", rdv0, 4);
    chk("t1_rd1_pulses", rdv1, 0);
    chk("t1_last_rd", last_rd, 8'hA3);

    // T2: tie after reset starts with req0, then alternates
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    order.delete();
    set_req(0, 3'd1, 16'h0100, 2'b00, 8'd0);
    set_req(1, 3'd2, 16'h0200, 2'b00, 8'd0);
    req_op_valid = 2'b11;
    serve_one(who);
    serve_one(who);
    req_op_valid = 2'b11;
    serve_one(who);
    serve_one(who);
    wait_idle("t2_idle_bound");
    chk("t2_order_len", order.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_order%0d", i), (order.size() > i) ? order[i] : 99, i % 2);
    end

    // T3: only the granted requester's write beats reach the drive
    wr_log.delete();
    req_wr_valid[0]     = 1'b1;
    req_wr_data[7:0]    = 8'h55;
    tick(2);
    chk("t3_idle_wr_valid", ctrl_wr_valid, 1'b0);
    set_req(1, 3'd2, 16'h0200, OP_WR, 8'd3);
    req_op_valid[1] = 1'b1;
    serve_one(who);
    chk("t3_who", who, 1);
    for (int b = 0; b < 3; b++) begin
      req_wr_data[15:8] = 8'(8'h11 * (b + 1));
      req_wr_sop[1]     = (b == 0);
      req_wr_eop[1]     = (b == 2);
      req_wr_valid[1]   = 1'b1;
      tick(1);
    end
    req_wr_valid[1] = 1'b0;
    req_wr_sop[1]   = 1'b0;
    req_wr_eop[1]   = 1'b0;
    wait_idle("t3_idle_bound");
    req_wr_valid[0] = 1'b0;
    chk("t3_beat_count", wr_log.size(), 3);
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("t3_beat%0d", b), (wr_log.size() > b) ? wr_log[b] : 10'h3FF, exp_beat[b]);
    end

    // T4: drive hangs -> watchdog release after 64 WAIT cycles
    hang = 1'b1;
    set_req(0, 3'd0, 16'h0300, 2'b00, 8'd0);
    req_op_valid[0] = 1'b1;
    serve_one(who);
    k = 0;
    while (!timeout && k < 200) begin
      tick(1);
      k++;
    end
    chk("t4_timeout_cycles", k, P_TO);
    chk("t4_grant_released", grant, 2'b00);
    tick(1);
    chk("t4_timeout_pulse", timeout, 1'b0);
    set_req(1, 3'd3, 16'h0400, 2'b00, 8'd0);
    req_op_valid[1] = 1'b1;
    tick(1);
    chk("t4_next_grant", grant, 2'b10);
    chk("t4_next_valid", ctrl_op_valid, 1'b1);
    chk("t4_next_not_ready", req_op_ready, 2'b00);
    tick(5);
    chk("t4_still_waiting", grant, 2'b10);
    hang = 1'b0;
    serve_one(who);
    chk("t4_who", who, 1);
    wait_idle("t4_idle_bound");

    // T5: async reset while in WAIT_DONE, pending req0 re-granted afterwards
    set_req(0, 3'd4, 16'h0500, 2'b00, 8'd0);
    req_op_valid[0] = 1'b1;
    serve_one(who);
    req_op_valid[0] = 1'b1;
    req_wr_valid[0] = 1'b1;
    tick(3);
    chk("t5_pre_grant", grant, 2'b01);
    chk("t5_pre_wr_valid", ctrl_wr_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", grant, 2'b00);
    chk("t5_rst_wr_valid", ctrl_wr_valid, 1'b0);
    chk("t5_rst_op_valid", ctrl_op_valid, 1'b0);
    chk("t5_rst_op_ready", req_op_ready, 2'b00);
    chk("t5_rst_timeout", timeout, 1'b0);
    req_wr_valid[0] = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("t5_regrant", grant, 2'b01);
    chk("t5_regrant_valid", ctrl_op_valid, 1'b1);
    serve_one(who);
    chk("t5_who", who, 0);
    wait_idle("t5_idle_bound");

    // T6: req0 withdraws in ISSUE, req1 gets the next grant
    stall = 1'b1;
    tick(1);
    set_req(0, 3'd6, 16'h0600, 2'b00, 8'd0);
    req_op_valid[0] = 1'b1;
    tick(1);
    chk("t6_grant0", grant, 2'b01);
    chk("t6_no_ready", req_op_ready, 2'b00);
    set_req(1, 3'd7, 16'h0700, 2'b00, 8'd0);
    req_op_valid[1] = 1'b1;
    tick(2);
    chk("t6_grant0_held", grant, 2'b01);
    n_order = order.size();
    req_op_valid[0] = 1'b0;
    tick(1);
    chk("t6_drop_idle", grant, 2'b00);
    tick(1);
    chk("t6_grant1", grant, 2'b10);
    stall = 1'b0;
    serve_one(who);
    chk("t6_who", who, 1);
    wait_idle("t6_idle_bound");
    chk("t6_accepts", order.size(), n_order + 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
